// File: rtl/synth_note_pkg.sv
// Shared widths, index defaults and search FSM state encoding for note_period_detector.
package synth_note_pkg;

   localparam int IDX_W       = 7;
   localparam int PER_W       = 16;
   localparam int MIN_IDX_DEF = 12;
   localparam int MAX_IDX_DEF = 119;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MEAS = 3'd1,
      S_RD   = 3'd2,
      S_CMP  = 3'd3,
      S_NA   = 3'd4,
      S_NB   = 3'd5,
      S_NC   = 3'd6,
      S_DONE = 3'd7
   } note_det_state_t;

endpackage

// File: rtl/note_edge_period.sv
// Synchronizes sig_in, detects rising edges and measures edge spacing with a
// saturating cycle counter; timeout is high while the counter sits at its maximum.
module note_edge_period
   import synth_note_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             sig_in,
   output logic             edge_stb,
   output logic [PER_W-1:0] period,
   output logic             timeout
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sig_prev;
   logic [PER_W-1:0]       cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q   <= '0;
         sig_prev <= 1'b0;
      end else begin
         sync_q[0] <= sig_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         sig_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_stb = sync_q[SYNC_STAGES-1] & ~sig_prev;

   // Restarting at 1 makes a period of N cycles read back as exactly N.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (edge_stb) begin
         cnt <= PER_W'(1);
      end else if (cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign period  = cnt;
   assign timeout = (cnt == '1);

endmodule

// File: rtl/note_period_detector.sv
// Measures the tone period and binary-searches the frequency ROM for the note index.
// NOTE_DET_NEAREST_EN enables nearest-neighbour refinement against rom[idx-1].
module note_period_detector
   import synth_note_pkg::*;
#(
   parameter int MIN_IDX     = MIN_IDX_DEF,
   parameter int MAX_IDX     = MAX_IDX_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             sig_in,
   output logic             rom_en,
   output logic [IDX_W-1:0] rom_addr,
   input  logic [PER_W-1:0] rom_data,
   output logic [IDX_W-1:0] note_out,
   output logic [PER_W-1:0] period_out,
   output logic             note_valid,
   output logic             range_err,
   output logic             no_signal,
   output logic             overrun,
   output logic             busy
);

   localparam logic [IDX_W-1:0] MIN_I = IDX_W'(MIN_IDX);
   localparam logic [IDX_W-1:0] MAX_I = IDX_W'(MAX_IDX);

   note_det_state_t  state;
   logic             edge_stb;
   logic             timeout;
   logic [PER_W-1:0] cnt_p;
   logic [PER_W-1:0] p_q;
   logic [IDX_W-1:0] lo_q, hi_q, idx_q;
   logic [IDX_W:0]   mid_sum;
   logic [IDX_W-1:0] mid, lo_n, hi_n;
   logic             err_q;
   logic             nb_err;
   logic             nb_rd;
`ifdef NOTE_DET_NEAREST_EN
   logic [PER_W-1:0] a_q;
   logic [PER_W-1:0] diff_b, diff_a;
`endif

   note_edge_period #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_period (
      .clk      (clk),
      .rstn     (rstn),
      .sig_in   (sig_in),
      .edge_stb (edge_stb),
      .period   (cnt_p),
      .timeout  (timeout)
   );

   always_comb begin
      mid_sum = {1'b0, lo_q} + {1'b0, hi_q};
      mid     = mid_sum[IDX_W:1];
      lo_n    = lo_q;
      hi_n    = hi_q;
      if (rom_data <= p_q) begin
         hi_n = mid;
      end else begin
         lo_n = mid + 1'b1;
      end
   end

   // Search lands on MAX only when every entry exceeds P, and on MIN with
   // rom[MIN] < P when P is longer than the lowest note.
   assign nb_err = (rom_data > p_q) | ((idx_q == MIN_I) & (p_q > rom_data));

`ifdef NOTE_DET_NEAREST_EN
   assign nb_rd  = (state == S_NB) & (idx_q > MIN_I) & ~nb_err;
   assign diff_b = rom_data - p_q;
   assign diff_a = p_q - a_q;
`else
   assign nb_rd  = 1'b0;
`endif

   assign rom_en = (state == S_RD) | (state == S_NA) | nb_rd;
   assign busy   = (state != S_IDLE) & (state != S_MEAS);

   always_comb begin
      rom_addr = '0;
      if (state == S_RD) begin
         rom_addr = mid;
      end else if (state == S_NA) begin
         rom_addr = idx_q;
      end else if (nb_rd) begin
         rom_addr = idx_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         p_q        <= '0;
         lo_q       <= '0;
         hi_q       <= '0;
         idx_q      <= '0;
         err_q      <= 1'b0;
         note_out   <= '0;
         period_out <= '0;
         note_valid <= 1'b0;
         range_err  <= 1'b0;
         no_signal  <= 1'b1;
         overrun    <= 1'b0;
`ifdef NOTE_DET_NEAREST_EN
         a_q        <= '0;
`endif
      end else begin
         note_valid <= 1'b0;
         overrun    <= edge_stb & busy;
         if (timeout) begin
            no_signal <= 1'b1;
         end
         case (state)
            S_IDLE: if (edge_stb) state <= S_MEAS;
            S_MEAS: begin
               if (edge_stb) begin
                  p_q   <= cnt_p;
                  lo_q  <= MIN_I;
                  hi_q  <= MAX_I;
                  state <= S_RD;
               end else if (timeout) begin
                  state <= S_IDLE;
               end
            end
            S_RD:   state <= S_CMP;
            S_CMP: begin
               lo_q <= lo_n;
               hi_q <= hi_n;
               if (lo_n < hi_n) begin
                  state <= S_RD;
               end else begin
                  idx_q <= lo_n;
                  state <= S_NA;
               end
            end
            S_NA:   state <= S_NB;
            S_NB: begin
               err_q <= nb_err;
`ifdef NOTE_DET_NEAREST_EN
               a_q   <= rom_data;
               state <= nb_rd ? S_NC : S_DONE;
`else
               state <= S_DONE;
`endif
            end
`ifdef NOTE_DET_NEAREST_EN
            // Ties keep idx, i.e. the higher note.
            S_NC: begin
               if (diff_b < diff_a) begin
                  idx_q <= idx_q - 1'b1;
               end
               state <= S_DONE;
            end
`endif
            S_DONE: begin
               note_out   <= idx_q;
               period_out <= p_q;
               range_err  <= err_q;
               note_valid <= 1'b1;
               no_signal  <= 1'b0;
               state      <= S_MEAS;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/note_period_detector.md
# note_period_detector

Measures the period of an incoming 1-bit tone signal in clock cycles and converts it back to a note index by searching the tri/squ/sin frequency ROM (`mem_rom_freq_tri_squ_sin`). This is the inverse of the ROM lookup: note index → period becomes period → note index. It sits beside the ROM as a second reader on its `en`/`addr`/`data_out` port and feeds note index, period and status flags to the control/tuner logic.

## Interface

**Parameters**
- `MIN_IDX`, default 12: lowest valid ROM index.
- `MAX_IDX`, default 119: highest valid ROM index.
- `SYNC_STAGES`, default 2: flip-flop count in the `sig_in` synchronizer.

**Ports**
- `clk`  in  1: system clock.
- `rstn`  in  1: reset. Asynchronous, active-low.
- `sig_in`  in  1: tone signal, asynchronous to `clk`.
- `rom_en`  out  1: ROM read enable.
- `rom_addr`  out  7: ROM index.
- `rom_data`  in  16: ROM registered output. Valid the cycle after `rom_en`=1.
- `note_out`  out  7: detected note index.
- `period_out`  out  16: captured period in clk cycles.
- `note_valid`  out  1: one-cycle pulse when `note_out`, `period_out` and `range_err` update.
- `range_err`  out  1: period lies outside the ROM range; `note_out` is clamped.
- `no_signal`  out  1: high from reset, and again after a counter timeout, until a valid period is measured.
- `overrun`  out  1: one-cycle pulse when an edge arrives while `busy`.
- `busy`  out  1: search in progress.

## Operation

**ROM contents**
- Entry i is the full period, rising edge to rising edge, in clk cycles.
- Entries strictly decrease over `MIN_IDX`..`MAX_IDX`.

**Period measurement**
- `sig_in` passes through a `SYNC_STAGES` synchronizer, then a rising-edge detector.
- Counter `cnt` (16 bit) increments every cycle and saturates at 16'hFFFF.
- On an edge: capture `P = cnt`, then set `cnt = 1`. A square wave of N cycles therefore gives P = N.
- The first edge after reset or after a timeout only arms the block; no search starts.
- Timeout: if `cnt` reaches 16'hFFFF, set `no_signal` = 1 and disarm.

**State machine**
- `S_IDLE`: disarmed. An edge moves to `S_MEAS`.
- `S_MEAS`: armed. An edge captures P and moves to `S_RD`. Timeout returns to `S_IDLE`.
- `S_RD`: issue `rom_en` with `rom_addr` = mid = (lo+hi)>>1, with lo = `MIN_IDX`, hi = `MAX_IDX` at entry. Go to `S_CMP`.
- `S_CMP`: if `rom_data` <= P then hi = mid, else lo = mid+1. If lo < hi after the update, return to `S_RD`; otherwise idx = lo and go to `S_NA`.
- `S_NA`: read rom[idx]. Go to `S_NB`.
- `S_NB`: latch A = rom[idx]. If idx > `MIN_IDX`, read rom[idx-1] and go to `S_NC`; else go to `S_DONE`.
- `S_NC`: latch B = rom[idx-1]. If (B − P) < (P − A), set idx = idx−1. Ties keep idx, the higher note.
- `S_DONE`: update outputs, pulse `note_valid`, clear `no_signal`, return to `S_MEAS`.

**Range check**
- `range_err` = 1 when P > rom[`MIN_IDX`]; `note_out` = `MIN_IDX`.
- `range_err` = 1 when P < rom[`MAX_IDX`]; `note_out` = `MAX_IDX`.
- Neighbour refinement is skipped in both range-error cases.

**Arithmetic**
- Differences are 16-bit unsigned. The operand order guarantees they never go negative.

**Edges while busy**
- `cnt` keeps running and restarts to 1 on the edge.
- That period is discarded and `overrun` pulses. The next edge is measured normally.

## Timing

**Reset values**
- `note_out` = 0, `period_out` = 0.
- `note_valid`, `range_err`, `overrun`, `busy`, `rom_en` = 0.
- `rom_addr` = 0.
- `no_signal` = 1.

**Latency**
- `busy` goes high the cycle after the capturing edge is detected.
- Binary search: at most 7 iterations of 2 cycles each.
- `note_valid` asserts no later than 20 cycles after the capturing edge. `busy` drops in the same cycle.

**Other timing rules**
- `rom_en` is high only in `S_RD`, `S_NA` and `S_NB` (the last only when reading idx-1).
- Reset mid-search aborts immediately. All outputs take their reset values and the block disarms.

## Configuration

`NOTE_DET_NEAREST_EN`
- Defined: nearest-neighbour refinement (`S_NC`) as described above.
- Undefined: the result is the search index idx (the smallest index with rom <= P). `S_NA`/`S_NB` perform only the range check, `S_NC` is removed, and ≤18-cycle latency applies.

## Structure

- Package `synth_note_pkg`:
  - `MIN_IDX`/`MAX_IDX` defaults.
  - Index width (7) and period width (16).
  - State enum `note_det_state_t`.
- Sub-module `note_edge_period`: synchronizer, edge detector, saturating counter and timeout. Outputs are the edge strobe, `P` and the timeout flag.
- The top level holds the search FSM and the output registers.

## Test plan

- Square wave with period 916 → after the arming edge, `note_valid` with `note_out` = 69, `period_out` = 916, `range_err` = 0.
- Period 944:
  - With the macro: `note_out` = 68 (971−944=27 < 944−916=28).
  - Without the macro: `note_out` = 69.
- Period 40 → `note_out` = 119, `range_err` = 1.
- Period 30000 → `note_out` = 12, `range_err` = 1.
- Stop toggling for 65535 cycles → `no_signal` = 1. The next edge only re-arms; a second edge yields a result.
- Edge spacing 10 cycles (P = 10, `range_err` = 1) with a third edge while `busy` → `overrun` pulse, no extra `note_valid`.
- Assert `rstn` mid-search → outputs at reset values, no `note_valid`.
